// File: rtl/bcd_word_validator.sv
// Streaming BCD guard stage: checks every 4-bit digit of a word for values
// above 9, registers the word together with its status in a single output
// stage, and keeps a saturating count plus a sticky flag of bad words.
module bcd_word_validator #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  parameter int BC_W   = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_digit_ok,
  output logic                  out_word_ok,
  output logic [IDX_W-1:0]      out_first_bad,
  output logic [BC_W-1:0]       out_bad_cnt,
  input  logic                  clr_err,
  output logic [CNT_W-1:0]      err_count,
  output logic                  err_sticky
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic              xfer;
  logic              load;
  logic [DIGITS-1:0] digit_ok;
  logic              word_ok;
  logic [IDX_W-1:0]  first_bad;
  logic [BC_W-1:0]   bad_cnt;
  logic              found;

  // The output stage is the only buffer, so a new word fits whenever it is
  // empty or its current word leaves this cycle.
  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign xfer      = in_valid && in_ready;

  // Per-digit legality, lowest bad index and bad-digit population count.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    digit_ok  = '0;
    first_bad = '0;
    bad_cnt   = '0;
    found     = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (in_data[4*k +: 4] > 4'd9) begin
        bad_cnt = bad_cnt + BC_W'(1);
        if (!found) begin
          first_bad = IDX_W'(k);
          found     = 1'b1;
        end
      end else begin
        digit_ok[k] = 1'b1;
      end
    end
  end

  assign word_ok = &digit_ok;

  // Output-stage next state and load enable.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (xfer) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer) begin
          load = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output-stage state register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Word and status registers; they hold their last value while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data      <= '0;
      out_digit_ok  <= '0;
      out_word_ok   <= 1'b0;
      out_first_bad <= '0;
      out_bad_cnt   <= '0;
    end else if (load) begin
      out_data      <= in_data;
      out_digit_ok  <= digit_ok;
      out_word_ok   <= word_ok;
      out_first_bad <= first_bad;
      out_bad_cnt   <= bad_cnt;
    end
  end

  // Bad-word accounting on input acceptance; a clear wins over a coincident
  // bad word, which is then not counted.
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (xfer && !word_ok) begin
      err_sticky <= 1'b1;
      if (err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
